// File: rtl/cpu7_ifu_isram_resp_pkg.sv
// Shared constants for the IFU instruction-SRAM responder.
// Holds the GR width, the fetch exception code and the FSM encoding.
package cpu7_ifu_isram_resp_pkg;

   localparam int GRLEN = 64;

   localparam logic [5:0] EXCCODE_ADEF = 6'h08;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

endpackage

// File: rtl/cpu7_ifu_isram_slot.sv
// Outstanding-fetch slot: live/ex/unc flags, wait counter, data buffer.
// All registers reset asynchronously to zero.
module cpu7_ifu_isram_slot (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        kill,
   input  logic        ex_in,
   input  logic        unc_in,
   input  logic [2:0]  cnt_in,
   input  logic        dec,
   input  logic        cap,
   input  logic [31:0] data_in,
   output logic        live,
   output logic        ex,
   output logic        unc,
   output logic [2:0]  cnt,
   output logic [31:0] data
);

   logic        live_q, live_d;
   logic        ex_q, ex_d;
   logic        unc_q, unc_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] data_q, data_d;

   // Next slot contents: a load in a kill cycle belongs to the new fetch.
   always_comb begin
      live_d = live_q;
      ex_d   = ex_q;
      unc_d  = unc_q;
      cnt_d  = cnt_q;
      data_d = data_q;
      if (kill) begin
         live_d = 1'b0;
      end
      if (load) begin
         live_d = 1'b1;
         ex_d   = ex_in;
         unc_d  = unc_in;
         cnt_d  = cnt_in;
      end else if (dec && cnt_q != 3'd0) begin
         cnt_d = cnt_q - 3'd1;
      end
      if (cap) begin
         data_d = data_in;
      end
   end

   // Slot registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         live_q <= 1'b0;
         ex_q   <= 1'b0;
         unc_q  <= 1'b0;
         cnt_q  <= 3'd0;
         data_q <= 32'd0;
      end else begin
         live_q <= live_d;
         ex_q   <= ex_d;
         unc_q  <= unc_d;
         cnt_q  <= cnt_d;
         data_q <= data_d;
      end
   end

   assign live = live_q;
   assign ex   = ex_q;
   assign unc  = unc_q;
   assign cnt  = cnt_q;
   assign data = data_q;

endmodule

// File: rtl/cpu7_ifu_isram_resp.sv
// IFU fetch responder in front of a synchronous instruction SRAM.
// One fetch in flight; response 1+WAIT cycles after acceptance.
module cpu7_ifu_isram_resp
   import cpu7_ifu_isram_resp_pkg::*;
#(
   parameter int         WAIT    = 0,
   parameter int         AW      = 14,
   parameter logic [2:0] UNC_SEG = 3'b101
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inst_req,
   input  logic [31:0]      inst_addr,
   input  logic             inst_cancel,
   output logic             inst_addr_ok,
   output logic             inst_valid_f,
   output logic [GRLEN-1:0] inst_rdata_f,
   output logic [1:0]       inst_count,
   output logic             inst_ex,
   output logic [5:0]       inst_exccode,
   output logic             inst_uncache,
   output logic             isram_en,
   output logic [AW-1:0]    isram_addr,
   input  logic [31:0]      isram_rdata
);

   localparam logic [2:0] WAIT_C = 3'(WAIT);

   logic [1:0]  state_q, state_d;
   logic        fresh_q, fresh_d;
   logic        accept;
   logic        misal;
   logic        is_resp;
   logic        slot_live;
   logic        slot_ex;
   logic        slot_unc;
   logic [2:0]  slot_cnt;
   logic [31:0] slot_data;
   logic [31:0] resp_data;
   logic        unused_addr;

   assign unused_addr = ^inst_addr;

   assign is_resp = (state_q == S_RESP);
   assign misal   = |inst_addr[1:0];

   // A new fetch is taken when idle or while the previous one responds.
   assign accept = inst_req & ~reset
                 & ((state_q == S_IDLE) | is_resp);

   assign inst_addr_ok = accept;
   assign isram_en     = accept & ~misal;
   assign isram_addr   = reset ? '0 : inst_addr[AW+1:2];

   // Sequencing through wait states towards the response cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = (WAIT_C == 3'd0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (slot_cnt <= 3'd1) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (accept) begin
               state_d = (WAIT_C == 3'd0) ? S_RESP : S_WAIT;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The cycle after acceptance the SRAM word is on isram_rdata.
   always_comb begin
      fresh_d = accept;
   end

   // FSM and capture-strobe registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         fresh_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fresh_q <= fresh_d;
      end
   end

   cpu7_ifu_isram_slot u_slot (
      .clk     (clk),
      .reset   (reset),
      .load    (accept),
      .kill    (inst_cancel),
      .ex_in   (misal),
      .unc_in  (inst_addr[31:29] == UNC_SEG),
      .cnt_in  (WAIT_C),
      .dec     (state_q == S_WAIT),
      .cap     (fresh_q),
      .data_in (isram_rdata),
      .live    (slot_live),
      .ex      (slot_ex),
      .unc     (slot_unc),
      .cnt     (slot_cnt),
      .data    (slot_data)
   );

   // Zero-wait fetches bypass the buffer straight from the SRAM.
   assign resp_data = fresh_q ? isram_rdata : slot_data;

   assign inst_valid_f = is_resp & slot_live
                       & ~inst_cancel & ~reset;

   // Response fields are forced to zero outside a valid response.
   always_comb begin
      inst_rdata_f = '0;
      inst_ex      = 1'b0;
      inst_exccode = 6'd0;
      inst_uncache = 1'b0;
      if (inst_valid_f) begin
         inst_uncache = slot_unc;
         if (slot_ex) begin
            inst_ex      = 1'b1;
            inst_exccode = EXCCODE_ADEF;
         end else begin
            inst_rdata_f = {{(GRLEN-32){1'b0}}, resp_data};
         end
      end
   end

   assign inst_count = {1'b0, inst_valid_f};

endmodule

// File: tb/tb_cpu7_ifu_isram_resp.sv
// Randomised bench for the fetch responder, WAIT=0 and WAIT=3 side by side.
// A due-cycle queue model predicts every output each cycle.
module tb_cpu7_ifu_isram_resp;

   logic        clk;
   logic        rst;
   logic        req;
   logic [31:0] addr;
   logic        cancel;

   logic        ok  [2];
   logic        vld [2];
   logic [63:0] rd  [2];
   logic [1:0]  cnt [2];
   logic        ex  [2];
   logic [5:0]  ec  [2];
   logic        unc [2];
   logic        en  [2];
   logic [13:0] sa  [2];
   logic [31:0] sr  [2];

   int wv [2] = '{0, 3};

   int checks;
   int errors;
   int cycle;
   int seq;

   bit          mbusy [2];
   bit          mlive [2];
   int          mdue  [2];
   logic [31:0] maddr [2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   cpu7_ifu_isram_resp #(.WAIT(0)) u_dut0 (
      .clk          (clk),
      .reset        (rst),
      .inst_req     (req),
      .inst_addr    (addr),
      .inst_cancel  (cancel),
      .inst_addr_ok (ok[0]),
      .inst_valid_f (vld[0]),
      .inst_rdata_f (rd[0]),
      .inst_count   (cnt[0]),
      .inst_ex      (ex[0]),
      .inst_exccode (ec[0]),
      .inst_uncache (unc[0]),
      .isram_en     (en[0]),
      .isram_addr   (sa[0]),
      .isram_rdata  (sr[0])
   );

   cpu7_ifu_isram_resp #(.WAIT(3)) u_dut3 (
      .clk          (clk),
      .reset        (rst),
      .inst_req     (req),
      .inst_addr    (addr),
      .inst_cancel  (cancel),
      .inst_addr_ok (ok[1]),
      .inst_valid_f (vld[1]),
      .inst_rdata_f (rd[1]),
      .inst_count   (cnt[1]),
      .inst_ex      (ex[1]),
      .inst_exccode (ec[1]),
      .inst_uncache (unc[1]),
      .isram_en     (en[1]),
      .isram_addr   (sa[1]),
      .isram_rdata  (sr[1])
   );

   function automatic logic [31:0] sram_word(logic [13:0] a);
      return (32'(a) * 32'h9E37_79B1) ^ 32'h1C00_BEEF;
   endfunction

   // One synchronous SRAM per DUT, read data the cycle after en.
   always @(posedge clk) begin
      if (en[0]) sr[0] <= sram_word(sa[0]);
      if (en[1]) sr[1] <= sram_word(sa[1]);
   end

   task automatic check(string tag, logic [63:0] got,
                        logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic check_zero(string t);
      for (int i = 0; i < 2; i++) begin
         check({t, "_ok"},  64'(ok[i]),  64'd0);
         check({t, "_vld"}, 64'(vld[i]), 64'd0);
         check({t, "_rd"},  rd[i],       64'd0);
         check({t, "_cnt"}, 64'(cnt[i]), 64'd0);
         check({t, "_ex"},  64'(ex[i]),  64'd0);
         check({t, "_ec"},  64'(ec[i]),  64'd0);
         check({t, "_unc"}, 64'(unc[i]), 64'd0);
         check({t, "_en"},  64'(en[i]),  64'd0);
         check({t, "_sa"},  64'(sa[i]),  64'd0);
      end
   endtask

   // Predict this cycle, compare, then advance the model past the edge.
   task automatic eval_cycle();
      for (int i = 0; i < 2; i++) begin
         bit resp, acc, val, xe, ue;
         logic [63:0] rde;
         string p;
         p    = $sformatf("w%0d_", wv[i]);
         resp = mbusy[i] && (cycle == mdue[i]);
         acc  = req && (!mbusy[i] || resp);
         val  = resp && mlive[i] && !cancel;
         xe   = maddr[i][1:0] != 2'b00;
         ue   = maddr[i][31:29] == 3'b101;
         rde  = (val && !xe) ? 64'(sram_word(maddr[i][15:2]))
                             : 64'd0;
         check({p, "ok"},  64'(ok[i]),  64'(acc));
         check({p, "en"},  64'(en[i]),
               64'(acc && addr[1:0] == 2'b00));
         if (acc && addr[1:0] == 2'b00)
            check({p, "sa"}, 64'(sa[i]), 64'(addr[15:2]));
         check({p, "vld"}, 64'(vld[i]), 64'(val));
         check({p, "cnt"}, 64'(cnt[i]), val ? 64'd1 : 64'd0);
         check({p, "rd"},  rd[i], rde);
         check({p, "ex"},  64'(ex[i]),  64'(val && xe));
         check({p, "ec"},  64'(ec[i]),
               (val && xe) ? 64'h08 : 64'd0);
         check({p, "unc"}, 64'(unc[i]), 64'(val && ue));
         if (cancel) mlive[i] = 1'b0;
         if (resp) mbusy[i] = 1'b0;
         if (acc) begin
            mbusy[i] = 1'b1;
            mlive[i] = 1'b1;
            mdue[i]  = cycle + 1 + wv[i];
            maddr[i] = addr;
         end
      end
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      logic [31:0] w;
      r = $urandom_range(0, 9);
      w = 32'($urandom_range(0, 16383)) << 2;
      if (r < 5) return 32'h1c00_0000 | w;
      if (r < 7) return 32'ha000_0000 | w;
      return 32'h1c00_0000 | w | 32'($urandom_range(1, 3));
   endfunction

   // mode 0: back-to-back sequential, 1: random, 2: sparse random.
   task automatic drive(int mode);
      case (mode)
         0: begin
            req    = 1'b1;
            cancel = 1'b0;
            addr   = 32'h1c00_0000 + 32'(seq) * 4;
            seq++;
         end
         1: begin
            req    = ($urandom_range(0, 3) != 0);
            cancel = ($urandom_range(0, 5) == 0);
            addr   = rand_addr();
         end
         default: begin
            req    = ($urandom_range(0, 3) == 0);
            cancel = ($urandom_range(0, 9) == 0);
            addr   = rand_addr();
         end
      endcase
   endtask

   task automatic run(int n, int mode);
      repeat (n) begin
         @(posedge clk);
         cycle++;
         #1;
         drive(mode);
         @(negedge clk);
         eval_cycle();
      end
   endtask

   // Reset asserted mid-cycle while fetches are in flight.
   task automatic do_reset(int hold);
      @(posedge clk);
      cycle++;
      #1;
      req    = 1'b1;
      cancel = 1'b0;
      addr   = 32'h1c00_0040;
      #2 rst = 1'b1;
      #1;
      check_zero("rst_async");
      for (int i = 0; i < 2; i++) begin
         mbusy[i] = 1'b0;
         mlive[i] = 1'b0;
      end
      repeat (hold) begin
         @(posedge clk);
         cycle++;
         #1;
         check_zero("rst_hold");
      end
      @(posedge clk);
      cycle++;
      #1;
      rst  = 1'b0;
      addr = 32'ha000_0008;
      @(negedge clk);
      eval_cycle();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cycle  = 0;
      seq    = 0;
      rst    = 1'b1;
      req    = 1'b1;
      cancel = 1'b0;
      addr   = 32'h1c00_0000;
      for (int i = 0; i < 2; i++) begin
         mbusy[i] = 1'b0;
         mlive[i] = 1'b0;
         mdue[i]  = 0;
         maddr[i] = 32'd0;
      end
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      req = 1'b0;
      @(negedge clk);
      eval_cycle();
      run(20, 0);
      run(6, 0);
      do_reset(2);
      run(400, 1);
      run(200, 2);
      run(12, 0);
      do_reset(1);
      run(800, 1);
      run(30, 0);
      run(300, 2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
